// File: rtl/tl_channel_buffer.sv
// TileLink A/D channel buffer: one circular FIFO per channel, plus an outstanding-request
// tracker that counts A requests against D responses.
module tl_channel_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CW    = (DEPTH == 0) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);
    if (DEPTH == 0) begin : g_pass
        assign out_valid = in_valid;
        assign out_data  = in_data;
        assign in_ready  = out_ready;
        assign count     = '0;
    end else begin : g_fifo
        localparam int PW = (DEPTH <= 1) ? 1 : $clog2(DEPTH);

        logic [WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]    rd_ptr;
        logic [PW-1:0]    wr_ptr;
        logic [CW-1:0]    cnt;
        logic             push;
        logic             pop;

        // Ready/valid come from the count alone, so out_ready never reaches in_ready.
        assign in_ready  = (cnt != CW'(DEPTH));
        assign out_valid = (cnt != '0);
        assign out_data  = mem[rd_ptr];
        assign count     = cnt;
        assign push      = in_valid && in_ready;
        assign pop       = out_valid && out_ready;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end

        // Storage is left uncleared on reset; only the pointers and count define contents.
        always_ff @(posedge clock) begin
            if (push) begin
                mem[wr_ptr] <= in_data;
            end
        end
    end
endmodule

module tl_channel_buffer #(
    parameter int A_DEPTH = 2,
    parameter int D_DEPTH = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SRC_W   = 1,
    parameter int SINK_W  = 1,
    parameter int OUT_W   = 4,
    localparam int MW     = DATA_W / 8,
    localparam int ACW    = (A_DEPTH == 0) ? 1 : $clog2(A_DEPTH + 1),
    localparam int DCW    = (D_DEPTH == 0) ? 1 : $clog2(D_DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_in_valid,
    output logic              a_in_ready,
    input  logic [2:0]        a_in_opcode,
    input  logic [2:0]        a_in_param,
    input  logic [2:0]        a_in_size,
    input  logic [SRC_W-1:0]  a_in_source,
    input  logic [ADDR_W-1:0] a_in_address,
    input  logic [MW-1:0]     a_in_mask,
    input  logic [DATA_W-1:0] a_in_data,
    input  logic              a_in_corrupt,
    output logic              a_out_valid,
    input  logic              a_out_ready,
    output logic [2:0]        a_out_opcode,
    output logic [2:0]        a_out_param,
    output logic [2:0]        a_out_size,
    output logic [SRC_W-1:0]  a_out_source,
    output logic [ADDR_W-1:0] a_out_address,
    output logic [MW-1:0]     a_out_mask,
    output logic [DATA_W-1:0] a_out_data,
    output logic              a_out_corrupt,
    input  logic              d_in_valid,
    output logic              d_in_ready,
    input  logic [2:0]        d_in_opcode,
    input  logic [1:0]        d_in_param,
    input  logic [2:0]        d_in_size,
    input  logic [SRC_W-1:0]  d_in_source,
    input  logic [SINK_W-1:0] d_in_sink,
    input  logic              d_in_denied,
    input  logic [DATA_W-1:0] d_in_data,
    input  logic              d_in_corrupt,
    output logic              d_out_valid,
    input  logic              d_out_ready,
    output logic [2:0]        d_out_opcode,
    output logic [1:0]        d_out_param,
    output logic [2:0]        d_out_size,
    output logic [SRC_W-1:0]  d_out_source,
    output logic [SINK_W-1:0] d_out_sink,
    output logic              d_out_denied,
    output logic [DATA_W-1:0] d_out_data,
    output logic              d_out_corrupt,
    output logic [ACW-1:0]    a_count,
    output logic [DCW-1:0]    d_count,
    output logic [OUT_W-1:0]  outstanding,
    output logic              idle,
    output logic              overflow_err
);
    localparam int AW = 9 + SRC_W + ADDR_W + MW + DATA_W + 1;
    localparam int DW = 8 + SRC_W + SINK_W + 1 + DATA_W + 1;

    logic [AW-1:0] a_in_pk;
    logic [AW-1:0] a_out_pk;
    logic [DW-1:0] d_in_pk;
    logic [DW-1:0] d_out_pk;
    logic          a_fire;
    logic          d_fire;

    assign a_in_pk = {a_in_opcode, a_in_param, a_in_size, a_in_source,
                      a_in_address, a_in_mask, a_in_data, a_in_corrupt};
    assign {a_out_opcode, a_out_param, a_out_size, a_out_source,
            a_out_address, a_out_mask, a_out_data, a_out_corrupt} = a_out_pk;
    assign d_in_pk = {d_in_opcode, d_in_param, d_in_size, d_in_source,
                      d_in_sink, d_in_denied, d_in_data, d_in_corrupt};
    assign {d_out_opcode, d_out_param, d_out_size, d_out_source,
            d_out_sink, d_out_denied, d_out_data, d_out_corrupt} = d_out_pk;

    tl_channel_fifo #(.WIDTH(AW), .DEPTH(A_DEPTH), .CW(ACW)) u_a_fifo (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_pk),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_pk),
        .count     (a_count)
    );

    tl_channel_fifo #(.WIDTH(DW), .DEPTH(D_DEPTH), .CW(DCW)) u_d_fifo (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (d_in_valid),
        .in_ready  (d_in_ready),
        .in_data   (d_in_pk),
        .out_valid (d_out_valid),
        .out_ready (d_out_ready),
        .out_data  (d_out_pk),
        .count     (d_count)
    );

    // Requests are counted as accepted from upstream, responses as delivered upstream.
    assign a_fire = a_in_valid && a_in_ready;
    assign d_fire = d_out_valid && d_out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outstanding  <= '0;
            overflow_err <= 1'b0;
        end else if (a_fire && !d_fire) begin
            if (outstanding == '1) begin
                overflow_err <= 1'b1;
            end else begin
                outstanding <= outstanding + 1'b1;
            end
        end else if (d_fire && !a_fire) begin
            if (outstanding == '0) begin
                overflow_err <= 1'b1;
            end else begin
                outstanding <= outstanding - 1'b1;
            end
        end
    end

    assign idle = (outstanding == '0) && (a_count == '0) && (d_count == '0);
endmodule

// File: tb/tb_tl_channel_buffer.sv
// Scoreboard bench for tl_channel_buffer: three instances (2/2, 8/4, 0/0) share one
// randomized stimulus stream; a negedge monitor checks each against queue/counter models.
module tb_tl_channel_buffer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic        a_in_valid, a_out_ready, d_in_valid, d_out_ready;
    logic [2:0]  a_in_opcode, a_in_param, a_in_size;
    logic        a_in_source;
    logic [31:0] a_in_address;
    logic [3:0]  a_in_mask;
    logic [31:0] a_in_data;
    logic        a_in_corrupt;
    logic [2:0]  d_in_opcode;
    logic [1:0]  d_in_param;
    logic [2:0]  d_in_size;
    logic        d_in_source, d_in_sink, d_in_denied;
    logic [31:0] d_in_data;
    logic        d_in_corrupt;
    logic [78:0] a_in_pk;
    logic [43:0] d_in_pk;

    assign a_in_pk = {a_in_opcode, a_in_param, a_in_size, a_in_source,
                      a_in_address, a_in_mask, a_in_data, a_in_corrupt};
    assign d_in_pk = {d_in_opcode, d_in_param, d_in_size, d_in_source,
                      d_in_sink, d_in_denied, d_in_data, d_in_corrupt};

    logic a_in_ready0, a_out_valid0, d_in_ready0, d_out_valid0, idle0, err0;
    logic [78:0] a_out0;
    logic [43:0] d_out0;
    logic [1:0]  a_count0, d_count0, outst0;

    logic a_in_ready1, a_out_valid1, d_in_ready1, d_out_valid1, idle1, err1;
    logic [78:0] a_out1;
    logic [43:0] d_out1;
    logic [3:0]  a_count1;
    logic [2:0]  d_count1;
    logic [3:0]  outst1;

    logic a_in_ready2, a_out_valid2, d_in_ready2, d_out_valid2, idle2, err2;
    logic [78:0] a_out2;
    logic [43:0] d_out2;
    logic [0:0]  a_count2, d_count2;
    logic [3:0]  outst2;

    tl_channel_buffer #(.A_DEPTH(2), .D_DEPTH(2), .OUT_W(2)) dut (
        .clock(clock), .reset(reset),
        .a_in_valid(a_in_valid), .a_in_ready(a_in_ready0),
        .a_in_opcode(a_in_opcode), .a_in_param(a_in_param), .a_in_size(a_in_size),
        .a_in_source(a_in_source), .a_in_address(a_in_address), .a_in_mask(a_in_mask),
        .a_in_data(a_in_data), .a_in_corrupt(a_in_corrupt),
        .a_out_valid(a_out_valid0), .a_out_ready(a_out_ready),
        .a_out_opcode(a_out0[78:76]), .a_out_param(a_out0[75:73]), .a_out_size(a_out0[72:70]),
        .a_out_source(a_out0[69]), .a_out_address(a_out0[68:37]), .a_out_mask(a_out0[36:33]),
        .a_out_data(a_out0[32:1]), .a_out_corrupt(a_out0[0]),
        .d_in_valid(d_in_valid), .d_in_ready(d_in_ready0),
        .d_in_opcode(d_in_opcode), .d_in_param(d_in_param), .d_in_size(d_in_size),
        .d_in_source(d_in_source), .d_in_sink(d_in_sink), .d_in_denied(d_in_denied),
        .d_in_data(d_in_data), .d_in_corrupt(d_in_corrupt),
        .d_out_valid(d_out_valid0), .d_out_ready(d_out_ready),
        .d_out_opcode(d_out0[43:41]), .d_out_param(d_out0[40:39]), .d_out_size(d_out0[38:36]),
        .d_out_source(d_out0[35]), .d_out_sink(d_out0[34]), .d_out_denied(d_out0[33]),
        .d_out_data(d_out0[32:1]), .d_out_corrupt(d_out0[0]),
        .a_count(a_count0), .d_count(d_count0), .outstanding(outst0),
        .idle(idle0), .overflow_err(err0)
    );

    tl_channel_buffer #(.A_DEPTH(8), .D_DEPTH(4), .OUT_W(4)) dut_w (
        .clock(clock), .reset(reset),
        .a_in_valid(a_in_valid), .a_in_ready(a_in_ready1),
        .a_in_opcode(a_in_opcode), .a_in_param(a_in_param), .a_in_size(a_in_size),
        .a_in_source(a_in_source), .a_in_address(a_in_address), .a_in_mask(a_in_mask),
        .a_in_data(a_in_data), .a_in_corrupt(a_in_corrupt),
        .a_out_valid(a_out_valid1), .a_out_ready(a_out_ready),
        .a_out_opcode(a_out1[78:76]), .a_out_param(a_out1[75:73]), .a_out_size(a_out1[72:70]),
        .a_out_source(a_out1[69]), .a_out_address(a_out1[68:37]), .a_out_mask(a_out1[36:33]),
        .a_out_data(a_out1[32:1]), .a_out_corrupt(a_out1[0]),
        .d_in_valid(d_in_valid), .d_in_ready(d_in_ready1),
        .d_in_opcode(d_in_opcode), .d_in_param(d_in_param), .d_in_size(d_in_size),
        .d_in_source(d_in_source), .d_in_sink(d_in_sink), .d_in_denied(d_in_denied),
        .d_in_data(d_in_data), .d_in_corrupt(d_in_corrupt),
        .d_out_valid(d_out_valid1), .d_out_ready(d_out_ready),
        .d_out_opcode(d_out1[43:41]), .d_out_param(d_out1[40:39]), .d_out_size(d_out1[38:36]),
        .d_out_source(d_out1[35]), .d_out_sink(d_out1[34]), .d_out_denied(d_out1[33]),
        .d_out_data(d_out1[32:1]), .d_out_corrupt(d_out1[0]),
        .a_count(a_count1), .d_count(d_count1), .outstanding(outst1),
        .idle(idle1), .overflow_err(err1)
    );

    tl_channel_buffer #(.A_DEPTH(0), .D_DEPTH(0), .OUT_W(4)) dut_p (
        .clock(clock), .reset(reset),
        .a_in_valid(a_in_valid), .a_in_ready(a_in_ready2),
        .a_in_opcode(a_in_opcode), .a_in_param(a_in_param), .a_in_size(a_in_size),
        .a_in_source(a_in_source), .a_in_address(a_in_address), .a_in_mask(a_in_mask),
        .a_in_data(a_in_data), .a_in_corrupt(a_in_corrupt),
        .a_out_valid(a_out_valid2), .a_out_ready(a_out_ready),
        .a_out_opcode(a_out2[78:76]), .a_out_param(a_out2[75:73]), .a_out_size(a_out2[72:70]),
        .a_out_source(a_out2[69]), .a_out_address(a_out2[68:37]), .a_out_mask(a_out2[36:33]),
        .a_out_data(a_out2[32:1]), .a_out_corrupt(a_out2[0]),
        .d_in_valid(d_in_valid), .d_in_ready(d_in_ready2),
        .d_in_opcode(d_in_opcode), .d_in_param(d_in_param), .d_in_size(d_in_size),
        .d_in_source(d_in_source), .d_in_sink(d_in_sink), .d_in_denied(d_in_denied),
        .d_in_data(d_in_data), .d_in_corrupt(d_in_corrupt),
        .d_out_valid(d_out_valid2), .d_out_ready(d_out_ready),
        .d_out_opcode(d_out2[43:41]), .d_out_param(d_out2[40:39]), .d_out_size(d_out2[38:36]),
        .d_out_source(d_out2[35]), .d_out_sink(d_out2[34]), .d_out_denied(d_out2[33]),
        .d_out_data(d_out2[32:1]), .d_out_corrupt(d_out2[0]),
        .a_count(a_count2), .d_count(d_count2), .outstanding(outst2),
        .idle(idle2), .overflow_err(err2)
    );

    // Reference state: one FIFO queue per buffered channel, one counter model per instance.
    logic [78:0] sbq [4][$];
    int          om [3];
    logic        em [3];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chan_step(input int ch, input int depth, input logic iv, input logic ir,
                             input logic [78:0] idat, input logic ov, input logic ordy,
                             input logic [78:0] odat, input int cnt);
        int sz;
        logic [78:0] head;
        sz = sbq[ch].size();
        chk($sformatf("count_ch%0d", ch), 128'(cnt), 128'(sz));
        chk($sformatf("in_ready_ch%0d", ch), 128'(ir), 128'(sz != depth));
        chk($sformatf("out_valid_ch%0d", ch), 128'(ov), 128'(sz != 0));
        if (ov && ordy) begin
            if (sz == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_empty_ch%0d actual=%0h expected=none t=%0t", ch, odat, $time);
            end else begin
                head = sbq[ch].pop_front();
                chk($sformatf("payload_ch%0d", ch), 128'(odat), 128'(head));
            end
        end
        if (iv && ir) sbq[ch].push_back(idat);
    endtask

    task automatic trk_step(input int k, input int maxv, input logic af, input logic df,
                            input int outst, input logic err, input logic idl,
                            input int cha, input int chd);
        logic idle_exp;
        idle_exp = (om[k] == 0);
        if (cha >= 0 && sbq[cha].size() != 0) idle_exp = 1'b0;
        if (chd >= 0 && sbq[chd].size() != 0) idle_exp = 1'b0;
        chk($sformatf("outstanding_%0d", k), 128'(outst), 128'(om[k]));
        chk($sformatf("overflow_err_%0d", k), 128'(err), 128'(em[k]));
        chk($sformatf("idle_%0d", k), 128'(idl), 128'(idle_exp));
        if (af && !df) begin
            if (om[k] == maxv) em[k] = 1'b1;
            else om[k]++;
        end else if (df && !af) begin
            if (om[k] == 0) em[k] = 1'b1;
            else om[k]--;
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) sbq[i].delete();
            for (int unsigned i = 0; i < 3; i++) begin
                om[i] = 0;
                em[i] = 1'b0;
            end
            chk("reset_dut", {a_out_valid0, d_out_valid0, a_in_ready0, d_in_ready0, idle0, err0,
                              outst0, a_count0, d_count0}, {6'b001110, 6'b0});
            chk("reset_dut_w", {a_out_valid1, d_out_valid1, a_in_ready1, d_in_ready1, idle1, err1,
                                outst1, a_count1, d_count1}, {6'b001110, 11'b0});
            chk("reset_dut_p", {idle2, err2, outst2}, {2'b10, 4'b0});
        end else begin
            trk_step(0, 3, a_in_valid && a_in_ready0, d_out_valid0 && d_out_ready,
                     int'(outst0), err0, idle0, 0, 1);
            chan_step(0, 2, a_in_valid, a_in_ready0, a_in_pk, a_out_valid0, a_out_ready,
                      a_out0, int'(a_count0));
            chan_step(1, 2, d_in_valid, d_in_ready0, 79'(d_in_pk), d_out_valid0, d_out_ready,
                      79'(d_out0), int'(d_count0));
            trk_step(1, 15, a_in_valid && a_in_ready1, d_out_valid1 && d_out_ready,
                     int'(outst1), err1, idle1, 2, 3);
            chan_step(2, 8, a_in_valid, a_in_ready1, a_in_pk, a_out_valid1, a_out_ready,
                      a_out1, int'(a_count1));
            chan_step(3, 4, d_in_valid, d_in_ready1, 79'(d_in_pk), d_out_valid1, d_out_ready,
                      79'(d_out1), int'(d_count1));
            // Pass-through: fires are defined by the bench's own valid/ready inputs.
            trk_step(2, 15, a_in_valid && a_out_ready, d_in_valid && d_out_ready,
                     int'(outst2), err2, idle2, -1, -1);
            chk("pass_a", {a_out_valid2, a_in_ready2, a_count2, a_out2},
                          {a_in_valid, a_out_ready, 1'b0, a_in_pk});
            chk("pass_d", {d_out_valid2, d_in_ready2, d_count2, d_out2},
                          {d_in_valid, d_out_ready, 1'b0, d_in_pk});
        end
    end

    task automatic rand_payload();
        a_in_opcode  = 3'($urandom);
        a_in_param   = 3'($urandom);
        a_in_size    = 3'($urandom);
        a_in_source  = 1'($urandom);
        a_in_address = $urandom;
        a_in_mask    = 4'($urandom);
        a_in_data    = $urandom;
        a_in_corrupt = 1'($urandom);
        d_in_opcode  = 3'($urandom);
        d_in_param   = 2'($urandom);
        d_in_size    = 3'($urandom);
        d_in_source  = 1'($urandom);
        d_in_sink    = 1'($urandom);
        d_in_denied  = 1'($urandom);
        d_in_data    = $urandom;
        d_in_corrupt = 1'($urandom);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        a_in_valid  = 1'b0;
        d_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        d_out_ready = 1'b0;
        rand_payload();
        do_reset();

        // Fill the 2-deep A queue, observe the stall, then drain in order.
        a_in_valid   = 1'b1;
        a_in_address = 32'h100;
        step();
        rand_payload();
        a_in_address = 32'h104;
        step();
        rand_payload();
        a_in_address = 32'h108;
        chk("a_full_count", 128'(a_count0), 128'd2);
        chk("a_full_ready", 128'(a_in_ready0), 128'd0);
        step();
        chk("a_stall_count", 128'(a_count0), 128'd2);
        chk("a_head_0x100", 128'(a_out0[68:37]), 128'h100);
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        step();
        chk("a_next_0x104", {a_out_valid0, a_out0[68:37]}, {1'b1, 32'h104});
        step();
        chk("a_drained", 128'(a_out_valid0), 128'd0);

        // Outstanding saturation at OUT_W=2 and stickiness of overflow_err.
        do_reset();
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            rand_payload();
            step();
        end
        chk("outst_three", {err0, outst0}, {1'b0, 2'd3});
        step();
        chk("outst_saturate", {err0, outst0}, {1'b1, 2'd3});
        a_in_valid  = 1'b0;
        d_out_ready = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            rand_payload();
            d_in_valid = 1'b1;
            step();
            d_in_valid = 1'b0;
            step();
        end
        chk("outst_sticky", {err0, outst0}, {1'b1, 2'd0});

        // Steady state at d_count=1: simultaneous push/pop for 10 cycles.
        d_out_ready = 1'b0;
        d_in_valid  = 1'b1;
        rand_payload();
        step();
        d_out_ready = 1'b1;
        for (int unsigned i = 0; i < 10; i++) begin
            rand_payload();
            step();
            chk("d_count_steady", 128'(d_count0), 128'd1);
        end
        d_in_valid = 1'b0;
        step();

        // Asynchronous reset between edges with a_count=2, d_count=1.
        a_out_ready = 1'b0;
        d_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        d_in_valid  = 1'b1;
        step();
        d_in_valid = 1'b0;
        rand_payload();
        step();
        a_in_valid = 1'b0;
        chk("pre_reset_counts", {a_count0, d_count0}, {2'd2, 2'd1});
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", {a_out_valid0, d_out_valid0, idle0, a_count0, d_count0},
                           {1'b0, 1'b0, 1'b1, 2'd0, 2'd0});
        step();
        reset = 1'b0;

        // Randomized traffic with varying back-pressure.
        for (int unsigned i = 0; i < 6000; i++) begin
            rand_payload();
            a_in_valid  = ($urandom_range(0, 3) != 0);
            d_in_valid  = ($urandom_range(0, 3) != 0);
            a_out_ready = (i % 1000 < 500) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
            d_out_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        a_in_valid  = 1'b0;
        d_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        d_out_ready = 1'b1;
        for (int unsigned i = 0; i < 20; i++) step();
        chk("drain_counts", {a_count0, d_count0, a_count1, d_count1}, 128'd0);
        do_reset();
        step();
        chk("final_idle", {idle0, idle1, idle2}, 128'h7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
